vga_rx_monitor: RTL and testbench

Receive-side monitor for the 8-bit TinyVGA output bus produced by the team's VGA designs. It samples the bus on the pixel clock, recovers pixel coordinates from hsync/vsync edges, measures line length and frame height, and declares lock after consecutive well-formed frames. It accumulates a per-frame colour checksum and captures the colour at a programmable probe coordinate. It sits in the bench/loopback path opposite the VGA generator, for self-checking of rendered frames.

---
 rtl/vga_rx_monitor.sv | 166 ++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// Receive-side monitor for the 8-bit TinyVGA bus: recovers pixel coordinates,
// measures line/frame timing, tracks lock, checksums frames and probes one pixel.
//
// state    | meaning
// S_UNLOCK | no good frame boundary since reset or the last bad boundary
// S_ONE    | one good frame boundary seen
// S_LOCKED | two or more consecutive good frame boundaries
module vga_rx_monitor #(
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_BACK   = 48,
   parameter int V_BACK   = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  vga_in,
   input  logic [9:0]  probe_x,
   input  logic [9:0]  probe_y,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [5:0]  pix_rgb,
   output logic        pix_valid,
   output logic [9:0]  line_len,
   output logic [9:0]  frame_lines,
   output logic [15:0] frame_sum,
   output logic        frame_done,
   output logic        locked,
   output logic [5:0]  probe_rgb,
   output logic        probe_hit
);

   localparam logic [1:0]  S_UNLOCK = 2'd0;
   localparam logic [1:0]  S_ONE    = 2'd1;
   localparam logic [1:0]  S_LOCKED = 2'd2;
   localparam logic [9:0]  CNT_MAX  = 10'h3ff;
   localparam logic [10:0] H_LO     = 11'(H_BACK);
   localparam logic [10:0] H_HI     = 11'(H_BACK + H_ACTIVE);
   localparam logic [10:0] V_LO     = 11'(V_BACK);
   localparam logic [10:0] V_HI     = 11'(V_BACK + V_ACTIVE);
   localparam logic [9:0]  H_OFS    = 10'(H_BACK);
   localparam logic [9:0]  V_OFS    = 10'(V_BACK);
   localparam logic [9:0]  H_TOT    = 10'(H_TOTAL);
   localparam logic [9:0]  V_TOT    = 10'(V_TOTAL);

   logic [7:0]  s1, s1_d;
   logic        h_rise, v_rise, anchor;
   logic [9:0]  hcnt, vcnt;
   logic [9:0]  hcnt_nxt, vcnt_nxt;
   logic [9:0]  len_meas, lines_meas;
   logic        have_h, have_v, v_pend, line_err;
   logic        err_eval, good, in_win, probe_match;
   logic [1:0]  state, state_nxt;
   logic [15:0] acc, acc_add;
   logic [5:0]  rgb_s1;

   // bus order is {hsync, B0, G0, R0, vsync, B1, G1, R1}
   assign h_rise  = s1[7] & ~s1_d[7];
   assign v_rise  = s1[3] & ~s1_d[3];
   assign anchor  = h_rise & v_pend;
   assign rgb_s1  = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};

   // hcnt/vcnt hold the index of the sample now in the output stage
   assign len_meas   = hcnt + 10'd1;
   assign lines_meas = vcnt + 10'd1;

   always_comb begin
      hcnt_nxt = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1;
      vcnt_nxt = vcnt;
      if (h_rise) begin
         hcnt_nxt = '0;
         if (anchor)
            vcnt_nxt = '0;
         else if (vcnt != CNT_MAX)
            vcnt_nxt = vcnt + 10'd1;
      end
   end

   assign in_win = (have_v | anchor)
                 & ({1'b0, hcnt_nxt} >= H_LO) & ({1'b0, hcnt_nxt} < H_HI)
                 & ({1'b0, vcnt_nxt} >= V_LO) & ({1'b0, vcnt_nxt} < V_HI);

   // the line closing at this h_rise still belongs to the ending frame
   assign err_eval = line_err | (h_rise & have_h & (len_meas != H_TOT));
   // the frame closed by the first anchor after reset is partial, hence have_v
   assign good     = have_h & have_v & ~err_eval & (lines_meas == V_TOT);

   always_comb begin
      state_nxt = state;
      if (anchor) begin
         if (!good)
            state_nxt = S_UNLOCK;
         else if (state == S_UNLOCK)
            state_nxt = S_ONE;
         else
            state_nxt = S_LOCKED;
      end
   end

   assign locked      = (state == S_LOCKED);
   assign acc_add     = acc + (pix_valid ? {10'b0, pix_rgb} : 16'd0);
   assign probe_match = pix_valid & (pix_x == probe_x) & (pix_y == probe_y);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1          <= '0;
         s1_d        <= '0;
         hcnt        <= '0;
         vcnt        <= '0;
         have_h      <= 1'b0;
         have_v      <= 1'b0;
         v_pend      <= 1'b0;
         line_err    <= 1'b0;
         state       <= S_UNLOCK;
         acc         <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         pix_valid   <= 1'b0;
         line_len    <= '0;
         frame_lines <= '0;
         frame_sum   <= '0;
         frame_done  <= 1'b0;
         probe_rgb   <= '0;
         probe_hit   <= 1'b0;
      end else begin
         s1        <= vga_in;
         s1_d      <= s1;
         hcnt      <= hcnt_nxt;
         vcnt      <= vcnt_nxt;
         state     <= state_nxt;
         pix_valid <= in_win;
         pix_x     <= in_win ? hcnt_nxt - H_OFS : 10'd0;
         pix_y     <= in_win ? vcnt_nxt - V_OFS : 10'd0;
         pix_rgb   <= rgb_s1;
         frame_done <= anchor;
         probe_hit <= probe_match;

         if (h_rise)
            have_h <= 1'b1;
         if (anchor)
            have_v <= 1'b1;
         if (v_rise)
            v_pend <= 1'b1;
         else if (anchor)
            v_pend <= 1'b0;

         if (h_rise & have_h)
            line_len <= len_meas;
         line_err <= anchor ? 1'b0 : err_eval;

         if (anchor) begin
            frame_lines <= lines_meas;
            frame_sum   <= acc_add;
            acc         <= '0;
         end else begin
            acc <= acc_add;
         end

         if (probe_match)
            probe_rgb <= pix_rgb;
      end
   end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced-size VGA generator model
// (48x14 total, 40x8 active) so full frames stay short.
module tb_vga_rx_monitor;

   localparam int HT = 48, VT = 14, HA = 40, VA = 8, HB = 4, VB = 3, HMID = 24;
   localparam int FRAME = HT * VT;
   localparam logic [5:0]  SOLID     = 6'b111000;
   localparam logic [15:0] SUM_SOLID = 16'd17920;
   localparam logic [15:0] SUM_RAMP  = 16'd6240;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  vga_in = 8'h00;
   logic [9:0]  probe_x = '0;
   logic [9:0]  probe_y = '0;
   logic [9:0]  pix_x, pix_y, line_len, frame_lines;
   logic [5:0]  pix_rgb, probe_rgb;
   logic        pix_valid, frame_done, locked, probe_hit;
   logic [15:0] frame_sum;

   int checks = 0;
   int errors = 0;

   // generator position (gh, gv) and the two/three previously driven samples
   int gh = 0, gv = 0, cur_len = HT, stretch_line = -1;
   bit drop_v = 1'b0, ramp = 1'b0;
   logic [5:0] c_cur = '0, c1 = '0, c2 = '0;
   int h1 = -1, v1 = -1, h2 = -1, v2 = -1, h3 = -1, v3 = -1;

   always #5 clk = ~clk;

   vga_rx_monitor #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
      .H_BACK(HB), .V_BACK(VB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .vga_in(vga_in),
      .probe_x(probe_x), .probe_y(probe_y),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
      .line_len(line_len), .frame_lines(frame_lines), .frame_sum(frame_sum),
      .frame_done(frame_done), .locked(locked),
      .probe_rgb(probe_rgb), .probe_hit(probe_hit)
   );

   function automatic bit in_act(int h, int v);
      return (h >= HB) && (h < HB + HA) && (v >= VB) && (v < VB + VA);
   endfunction

   function automatic logic [5:0] colour(int h, int v);
      if (!in_act(h, v)) return 6'd0;
      if (ramp) return 6'(h - HB);
      return SOLID;
   endfunction

   function automatic logic [7:0] enc(int h, int v, logic [5:0] c);
      logic hs, vs;
      hs = (h < cur_len - 3);
      vs = drop_v || !((v == VT - 3 && h >= HMID) || v == VT - 2 || (v == VT - 1 && h < HMID));
      return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
   endfunction

   function automatic logic [71:0] all_outs();
      return {pix_x, pix_y, pix_rgb, pix_valid, line_len, frame_lines, frame_sum,
              frame_done, locked, probe_rgb, probe_hit};
   endfunction

   task automatic drive();
      c_cur  = colour(gh, gv);
      vga_in = enc(gh, gv, c_cur);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      h3 = h2; v3 = v2;
      h2 = h1; v2 = v1; c2 = c1;
      h1 = gh; v1 = gv; c1 = c_cur;
      gh++;
      if (gh >= cur_len) begin
         gh = 0;
         gv++;
         if (gv == VT) begin
            gv = 0;
            drop_v = 1'b0;
         end
         cur_len = (gv == stretch_line) ? HT + 1 : HT;
         if (gv == stretch_line) stretch_line = -1;
      end
      drive();
   endtask

   task automatic test_reset();
      gh = 0; gv = VT - 2; cur_len = HT;
      drive();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pix_x, pix_y, pix_rgb, pix_valid} !== 27'd0) begin
         errors++;
         $display("FAIL reset_pix: got %h, want 0", {pix_x, pix_y, pix_rgb, pix_valid});
      end
      checks++;
      if ({line_len, frame_lines, frame_sum, frame_done} !== 37'd0) begin
         errors++;
         $display("FAIL reset_frame: got %h, want 0", {line_len, frame_lines, frame_sum, frame_done});
      end
      checks++;
      if ({locked, probe_rgb, probe_hit} !== 8'd0) begin
         errors++;
         $display("FAIL reset_lock_probe: got %h, want 0", {locked, probe_rgb, probe_hit});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lock();
      int fd, n;
      bit exp_v;
      logic [9:0] exp_x, exp_y, exp_lines;
      logic [15:0] exp_sum;
      fd = 0; n = 0;
      while (fd < 3 && n < 5 * FRAME) begin
         step();
         n++;
         exp_v = (fd > 0) && in_act(h2, v2);
         exp_x = exp_v ? 10'(h2 - HB) : 10'd0;
         exp_y = exp_v ? 10'(v2 - VB) : 10'd0;
         checks++;
         if (pix_valid !== exp_v || pix_x !== exp_x || pix_y !== exp_y || pix_rgb !== c2) begin
            errors++;
            $display("FAIL lock_pix at (%0d,%0d): got v=%b x=%0d y=%0d rgb=%b, want v=%b x=%0d y=%0d rgb=%b",
                     h2, v2, pix_valid, pix_x, pix_y, pix_rgb, exp_v, exp_x, exp_y, c2);
         end
         checks++;
         if (frame_done !== logic'(h2 == 0 && v2 == 0)) begin
            errors++;
            $display("FAIL lock_done_timing at (%0d,%0d): got %b", h2, v2, frame_done);
         end
         if (frame_done === 1'b1) begin
            exp_lines = (fd == 0) ? 10'd3 : 10'(VT);
            exp_sum   = (fd == 0) ? 16'd0 : SUM_SOLID;
            checks++;
            if (frame_lines !== exp_lines || locked !== logic'(fd == 2) ||
                frame_sum !== exp_sum || line_len !== 10'(HT)) begin
               errors++;
               $display("FAIL lock_boundary %0d: got lines=%0d locked=%b sum=%0d len=%0d, want lines=%0d locked=%b sum=%0d len=%0d",
                        fd + 1, frame_lines, locked, frame_sum, line_len, exp_lines, fd == 2, exp_sum, HT);
            end
            fd++;
         end
      end
      checks++;
      if (fd < 3) begin
         errors++;
         $display("FAIL lock_timeout: got %0d boundaries, want 3", fd);
      end
   endtask

   task automatic test_probe();
      int px[2];
      int py[2];
      int hits;
      px = '{0, HA - 1};
      py = '{0, VA - 1};
      for (int k = 0; k < 2; k++) begin
         hits = 0;
         probe_x = 10'(px[k]);
         probe_y = 10'(py[k]);
         for (int i = 0; i < FRAME; i++) begin
            step();
            checks++;
            if (probe_hit !== logic'(h3 == px[k] + HB && v3 == py[k] + VB)) begin
               errors++;
               $display("FAIL probe_hit_timing probe(%0d,%0d) at sample (%0d,%0d): got %b",
                        px[k], py[k], h3, v3, probe_hit);
            end
            if (probe_hit === 1'b1) begin
               hits++;
               checks++;
               if (probe_rgb !== SOLID) begin
                  errors++;
                  $display("FAIL probe_rgb: got %b, want %b", probe_rgb, SOLID);
               end
            end
         end
         checks++;
         if (hits != 1) begin
            errors++;
            $display("FAIL probe_hit_count probe(%0d,%0d): got %0d, want 1", px[k], py[k], hits);
         end
      end
   endtask

   task automatic test_ramp();
      int nvalid;
      nvalid = 0;
      ramp = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         step();
         checks++;
         if (pix_rgb !== c2) begin
            errors++;
            $display("FAIL ramp_rgb at (%0d,%0d): got %b, want %b", h2, v2, pix_rgb, c2);
         end
         if (pix_valid === 1'b1) begin
            nvalid++;
            checks++;
            if (pix_rgb !== pix_x[5:0]) begin
               errors++;
               $display("FAIL ramp_rgb_vs_x: got rgb=%b x=%0d", pix_rgb, pix_x);
            end
         end
      end
      ramp = 1'b0;
      checks++;
      if (nvalid != HA * VA) begin
         errors++;
         $display("FAIL ramp_valid_count: got %0d, want %0d", nvalid, HA * VA);
      end
      checks++;
      if (frame_done !== 1'b1 || frame_sum !== SUM_RAMP || locked !== 1'b1) begin
         errors++;
         $display("FAIL ramp_boundary: got done=%b sum=%0d locked=%b, want done=1 sum=%0d locked=1",
                  frame_done, frame_sum, locked, SUM_RAMP);
      end
   endtask

   task automatic test_stretch();
      int fd, n;
      fd = 0; n = 0;
      stretch_line = 5;
      while (fd < 3 && n < 5 * FRAME) begin
         step();
         n++;
         if (fd == 0 && h2 == 0 && (v2 == 6 || v2 == 7)) begin
            checks++;
            if (line_len !== ((v2 == 6) ? 10'(HT + 1) : 10'(HT))) begin
               errors++;
               $display("FAIL stretch_line_len at line %0d: got %0d", v2, line_len);
            end
         end
         if (frame_done === 1'b1) begin
            checks++;
            if (locked !== logic'(fd == 2) || frame_lines !== 10'(VT) ||
                (fd == 0 && n != FRAME + 1)) begin
               errors++;
               $display("FAIL stretch_boundary %0d: got locked=%b lines=%0d step=%0d, want locked=%b lines=%0d",
                        fd + 1, locked, frame_lines, n, fd == 2, VT);
            end
            fd++;
         end
      end
      checks++;
      if (fd < 3) begin
         errors++;
         $display("FAIL stretch_timeout: got %0d boundaries, want 3", fd);
      end
   endtask

   task automatic test_drop_vsync();
      int fd, n;
      fd = 0; n = 0;
      drop_v = 1'b1;
      while (fd < 3 && n < 6 * FRAME) begin
         step();
         n++;
         if (frame_done === 1'b1) begin
            checks++;
            if (fd == 0) begin
               if (frame_lines !== 10'(2 * VT) || locked !== 1'b0 || n != 2 * FRAME) begin
                  errors++;
                  $display("FAIL drop_boundary: got lines=%0d locked=%b step=%0d, want lines=%0d locked=0 step=%0d",
                           frame_lines, locked, n, 2 * VT, 2 * FRAME);
               end
            end else if (frame_lines !== 10'(VT) || locked !== logic'(fd == 2)) begin
               errors++;
               $display("FAIL drop_relock %0d: got lines=%0d locked=%b, want lines=%0d locked=%b",
                        fd, frame_lines, locked, VT, fd == 2);
            end
            fd++;
         end
      end
      checks++;
      if (fd < 3) begin
         errors++;
         $display("FAIL drop_timeout: got %0d boundaries, want 3", fd);
      end
   endtask

   task automatic test_reset_mid();
      int fd, n;
      fd = 0; n = 0;
      while (!(gh == 8 && gv == VT - 2) && n < 2 * FRAME) begin
         step();
         n++;
      end
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_locked: got %b, want 1", locked);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (all_outs() !== 72'd0) begin
         errors++;
         $display("FAIL async_reset: got %h, want 0", all_outs());
      end
      repeat (3) begin
         step();
         checks++;
         if (all_outs() !== 72'd0) begin
            errors++;
            $display("FAIL held_reset: got %h, want 0", all_outs());
         end
      end
      rst_n = 1'b1;
      n = 0;
      while (fd < 3 && n < 5 * FRAME) begin
         step();
         n++;
         if (fd == 0) begin
            checks++;
            if (pix_valid !== 1'b0) begin
               errors++;
               $display("FAIL unanchored_valid: got %b, want 0", pix_valid);
            end
         end
         if (frame_done === 1'b1) begin
            checks++;
            if (locked !== logic'(fd == 2) || frame_lines !== ((fd == 0) ? 10'd3 : 10'(VT)) ||
                (fd == 0 && frame_sum !== 16'd0)) begin
               errors++;
               $display("FAIL reset_relock %0d: got locked=%b lines=%0d sum=%0d",
                        fd + 1, locked, frame_lines, frame_sum);
            end
            fd++;
         end
      end
      checks++;
      if (fd < 3) begin
         errors++;
         $display("FAIL reset_relock_timeout: got %0d boundaries, want 3", fd);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_probe();
      test_ramp();
      test_stretch();
      test_drop_vsync();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
